// File: rtl/aes_pkg.sv
// Shared AES byte-substitution constants and GF(2^8) helper functions.
// Field arithmetic is modulo x^8+x^4+x^3+x+1.
package aes_pkg;

    localparam int unsigned NB_BYTE           = 8;
    localparam logic [7:0]  SBOX_AFFINE_C     = 8'h63;
    localparam logic [7:0]  SBOX_INV_AFFINE_C = 8'h05;
    localparam logic [8:0]  GF_POLY           = 9'h11B;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        return gf_mul(a, a);
    endfunction

    // Forward affine map including the 0x63 constant.
    function automatic logic [7:0] sbox_affine(input logic [7:0] x);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8];
        end
        return b ^ SBOX_AFFINE_C;
    endfunction

    function automatic logic [7:0] sbox_inv_affine(input logic [7:0] x);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
        end
        return b ^ SBOX_INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/sbox_pipeline_engine_if.sv
// Word-level valid/ready bus between the round-key-add stage, the S-box engine and ShiftRows.
interface sbox_pipeline_engine_if #(
    parameter int unsigned NB_LANES = 16,
    parameter int unsigned NB_BYTE  = 8
);
    logic [NB_LANES*NB_BYTE-1:0] i_data;
    logic                        i_valid;
    logic                        i_inverse;
    logic                        o_ready;
    logic [NB_LANES*NB_BYTE-1:0] o_data;
    logic                        o_valid;
    logic                        i_ready;
    logic                        o_busy;

    modport master (
        output i_data, i_valid, i_inverse, i_ready,
        input  o_ready, o_data, o_valid, o_busy
    );

    modport slave (
        input  i_data, i_valid, i_inverse, i_ready,
        output o_ready, o_data, o_valid, o_busy
    );
endinterface

// File: rtl/gf256_inverse_byte.sv
// Combinational GF(2^8) multiplicative inverse, inv(0) = 0.
// Goes through the GF(2^4) subfield: x^17 lies in GF(16), whose inverse is its 14th power.
module gf256_inverse_byte
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] inv_o
);
    logic [7:0] a2, a4, a8, a16;
    logic [7:0] y, y2, y4, y8, y_inv;

    always_comb begin
        a2    = gf_sq(a_i);
        a4    = gf_sq(a2);
        a8    = gf_sq(a4);
        a16   = gf_sq(a8);
        y     = gf_mul(a16, a_i);
        y2    = gf_sq(y);
        y4    = gf_sq(y2);
        y8    = gf_sq(y4);
        y_inv = gf_mul(gf_mul(y8, y4), y2);
        // x^-1 = x^254 = (x^17)^14 * x^16
        inv_o = gf_mul(y_inv, a16);
    end
endmodule

// File: rtl/sbox_pipeline_engine.sv
// Pipelined forward/inverse AES S-box over NB_LANES bytes with per-word mode select.
// Stages: pre-transform, GF inversion, post-transform, folded into NB_PIPE registers.
module sbox_pipeline_engine #(
    parameter int unsigned NB_BYTE  = aes_pkg::NB_BYTE,
    parameter int unsigned NB_LANES = 16,
    parameter int unsigned NB_PIPE  = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    sbox_pipeline_engine_if.slave bus_io
);
    import aes_pkg::*;

    localparam int unsigned W = NB_LANES * NB_BYTE;
    localparam bit BAD_CONF = (NB_BYTE != 8) || (NB_LANES < 1) || (NB_LANES > 32) ||
                              (NB_PIPE < 1) || (NB_PIPE > 3);

    if (BAD_CONF) begin : g_bad_conf
        $error("sbox_pipeline_engine: illegal NB_BYTE/NB_LANES/NB_PIPE configuration");
    end

    logic [W-1:0]       pre_w, inv_in_w, inv_out_w, post_in_w, post_out_w;
    logic               post_mode_w;
    logic [W-1:0]       stage_d [NB_PIPE];
    logic [W-1:0]       data_q  [NB_PIPE];
    logic [NB_PIPE-1:0] valid_d, valid_q;
    logic               advance, accept;

    always_comb begin
        pre_w      = '0;
        post_out_w = '0;
        for (int unsigned k = 0; k < NB_LANES; k++) begin
            pre_w[k*8 +: 8]      = bus_io.i_inverse ? sbox_inv_affine(bus_io.i_data[k*8 +: 8])
                                                    : bus_io.i_data[k*8 +: 8];
            post_out_w[k*8 +: 8] = post_mode_w ? post_in_w[k*8 +: 8]
                                               : sbox_affine(post_in_w[k*8 +: 8]);
        end
    end

    for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
        gf256_inverse_byte u_inv (
            .a_i   (inv_in_w[k*8 +: 8]),
            .inv_o (inv_out_w[k*8 +: 8])
        );
    end

    // The mode bit is only kept in registers that feed a later mode-dependent stage.
    if (NB_PIPE == 1) begin : g_pipe1
        assign inv_in_w    = pre_w;
        assign post_in_w   = inv_out_w;
        assign post_mode_w = bus_io.i_inverse;
        assign stage_d[0]  = post_out_w;
    end else if (NB_PIPE == 2) begin : g_pipe2
        logic mode_q;

        always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset) begin
                mode_q <= 1'b0;
            end else if (advance && accept) begin
                mode_q <= bus_io.i_inverse;
            end
        end

        assign inv_in_w    = data_q[0];
        assign post_in_w   = inv_out_w;
        assign post_mode_w = mode_q;
        assign stage_d[0]  = pre_w;
        assign stage_d[1]  = post_out_w;
    end else begin : g_pipe3
        logic [1:0] mode_q;

        always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset) begin
                mode_q <= '0;
            end else if (advance) begin
                if (accept)     mode_q[0] <= bus_io.i_inverse;
                if (valid_q[0]) mode_q[1] <= mode_q[0];
            end
        end

        assign inv_in_w    = data_q[0];
        assign post_in_w   = data_q[1];
        assign post_mode_w = mode_q[1];
        assign stage_d[0]  = pre_w;
        assign stage_d[1]  = inv_out_w;
        assign stage_d[2]  = post_out_w;
    end

    always_comb begin
        advance    = ~valid_q[NB_PIPE-1] | bus_io.i_ready;
        accept     = bus_io.i_valid & advance;
        valid_d    = '0;
        valid_d[0] = accept;
        for (int unsigned k = 1; k < NB_PIPE; k++) begin
            valid_d[k] = valid_q[k-1];
        end
    end

    // Data registers only load behind a valid word; bubbles leave them untouched.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < NB_PIPE; k++) data_q[k] <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
            for (int unsigned k = 0; k < NB_PIPE; k++) begin
                if (valid_d[k]) data_q[k] <= stage_d[k];
            end
        end
    end

    assign bus_io.o_valid = valid_q[NB_PIPE-1];
    assign bus_io.o_data  = data_q[NB_PIPE-1];
    assign bus_io.o_busy  = |valid_q;
    assign bus_io.o_ready = advance;

endmodule

// File: tb/tb_sbox_pipeline_engine.sv
// Bench for sbox_pipeline_engine: known-answer table, exhaustive and random streams against
// a table-based S-box model, plus backpressure, reset and other pipeline depths / lane counts.
module tb_sbox_pipeline_engine;

    localparam int unsigned LANES = 4;
    localparam int unsigned PIPE  = 2;
    localparam int unsigned W     = LANES * 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sbox_pipeline_engine_if #(.NB_LANES(LANES), .NB_BYTE(8)) bus  ();
    sbox_pipeline_engine_if #(.NB_LANES(16),    .NB_BYTE(8)) bus1 ();
    sbox_pipeline_engine_if #(.NB_LANES(1),     .NB_BYTE(8)) bus3 ();

    sbox_pipeline_engine #(.NB_BYTE(8), .NB_LANES(LANES), .NB_PIPE(PIPE)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus_io  (bus)
    );
    sbox_pipeline_engine #(.NB_BYTE(8), .NB_LANES(16), .NB_PIPE(1)) dut_p1 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus_io  (bus1)
    );
    sbox_pipeline_engine #(.NB_BYTE(8), .NB_LANES(1), .NB_PIPE(3)) dut_p3 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus_io  (bus3)
    );

    int n_cmp;
    int n_fail;
    logic [7:0] sbox_m  [256];
    logic [7:0] isbox_m [256];
    logic [W-1:0] exp_q [$];
    bit           stall_prev;
    logic [W-1:0] data_prev;
    int           acc_cnt;

    typedef struct {
        logic [31:0] din;
        bit          inv;
        logic [31:0] dout;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [127:0] model_word(input logic [127:0] d, input bit inv,
                                                input int lanes);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < lanes; k++) begin
            r[k*8 +: 8] = inv ? isbox_m[d[k*8 +: 8]] : sbox_m[d[k*8 +: 8]];
        end
        return r;
    endfunction

    // One clock of the main DUT: drive at negedge, observe the handshake the next posedge sees.
    task automatic cycle(input bit v, input logic [W-1:0] d, input bit inv, input bit rdy);
        @(negedge clk);
        bus.i_valid   = v;
        bus.i_data    = d;
        bus.i_inverse = inv;
        bus.i_ready   = rdy;
        #1;
        check("busy", 128'(bus.o_busy), 128'(exp_q.size() != 0));
        if (stall_prev) check("stall_hold", 128'(bus.o_data), 128'(data_prev));
        if (rdy || !bus.o_valid) check("ready_free", 128'(bus.o_ready), 128'(1));
        else                     check("ready_stall", 128'(bus.o_ready), 128'(0));
        if (bus.o_valid && rdy) begin
            if (exp_q.size() == 0) check("spurious_out", 128'(bus.o_valid), 128'(0));
            else                   check("out_data", 128'(bus.o_data), 128'(exp_q.pop_front()));
        end
        if (v && bus.o_ready) begin
            exp_q.push_back(W'(model_word(128'(d), inv, LANES)));
            acc_cnt++;
        end
        stall_prev = bus.o_valid && !rdy;
        data_prev  = bus.o_data;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            budget++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic run_p1(input logic [127:0] d, input bit inv);
        int lat;
        @(negedge clk);
        bus1.i_valid = 1'b1; bus1.i_data = d; bus1.i_inverse = inv; bus1.i_ready = 1'b1;
        @(negedge clk);
        bus1.i_valid = 1'b0;
        lat = 1;
        while (!bus1.o_valid && lat < 10) begin @(negedge clk); lat++; end
        check("p1_latency", 128'(lat), 128'(1));
        check("p1_data", bus1.o_data, model_word(d, inv, 16));
        @(negedge clk);
    endtask

    task automatic run_p3(input logic [7:0] d, input bit inv);
        int lat;
        @(negedge clk);
        bus3.i_valid = 1'b1; bus3.i_data = d; bus3.i_inverse = inv; bus3.i_ready = 1'b1;
        @(negedge clk);
        bus3.i_valid = 1'b0;
        lat = 1;
        while (!bus3.o_valid && lat < 10) begin @(negedge clk); lat++; end
        check("p3_latency", 128'(lat), 128'(3));
        check("p3_data", 128'(bus3.o_data), model_word(128'(d), inv, 1));
        @(negedge clk);
    endtask

    task automatic fill_p3();
        logic [7:0] q [$];
        logic [7:0] d;
        int acc;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d = 8'($urandom);
            bus3.i_valid = 1'b1; bus3.i_data = d; bus3.i_inverse = 1'(i % 2); bus3.i_ready = 1'b0;
            #1;
            if (bus3.o_ready) begin
                acc++;
                q.push_back(8'(model_word(128'(d), 1'(i % 2), 1)));
            end
        end
        check("p3_fill", 128'(acc), 128'(3));
        @(negedge clk);
        bus3.i_valid = 1'b0; bus3.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("p3_drain_valid", 128'(bus3.o_valid), 128'(1));
            if (q.size() != 0) check("p3_drain", 128'(bus3.o_data), 128'(q.pop_front()));
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : main
        logic [W-1:0] d;
        logic [7:0]   iv, s;
        int           lat, m, idx;

        n_cmp = 0; n_fail = 0; stall_prev = 1'b0; data_prev = '0; acc_cnt = 0;
        bus.i_valid = 1'b0;  bus.i_data = '0;  bus.i_inverse = 1'b0;  bus.i_ready = 1'b0;
        bus1.i_valid = 1'b0; bus1.i_data = '0; bus1.i_inverse = 1'b0; bus1.i_ready = 1'b1;
        bus3.i_valid = 1'b0; bus3.i_data = '0; bus3.i_inverse = 1'b0; bus3.i_ready = 1'b1;

        for (int x = 0; x < 256; x++) begin
            iv = '0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
            sbox_m[x]  = s;
            isbox_m[s] = 8'(x);
        end

        vecs[0] = '{32'hFF530100, 1'b0, 32'h16ED7C63};
        vecs[1] = '{32'h16ED7C63, 1'b1, 32'hFF530100};
        vecs[2] = '{32'h30201000, 1'b0, 32'h04B7CA63};
        vecs[3] = '{32'h04B7CA63, 1'b1, 32'h30201000};
        vecs[4] = '{32'h03020100, 1'b1, 32'hD56A0952};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 128'(bus.o_valid), 128'(0));
        check("rst_busy",  128'(bus.o_busy),  128'(0));
        check("rst_data",  128'(bus.o_data),  128'(0));
        check("rst_ready", 128'(bus.o_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.i_valid = 1'b1; bus.i_data = vecs[i].din; bus.i_inverse = vecs[i].inv;
            bus.i_ready = 1'b1;
            #1 check("vec_ready", 128'(bus.o_ready), 128'(1));
            @(negedge clk);
            bus.i_valid = 1'b0;
            lat = 1;
            while (!bus.o_valid && lat < 10) begin @(negedge clk); lat++; end
            check("vec_latency", 128'(lat), 128'(PIPE));
            check("vec_data", 128'(bus.o_data), 128'(vecs[i].dout));
        end

        // Exhaustive, alternating forward/inverse words back-to-back.
        for (int j = 0; j < 512; j++) begin
            m = j / 2;
            for (int k = 0; k < int'(LANES); k++) begin
                idx = (m + k * 64) % 256;
                d[k*8 +: 8] = (j % 2 == 0) ? 8'(idx) : sbox_m[idx];
            end
            cycle(1'b1, d, 1'(j % 2), 1'b1);
            if (j >= int'(PIPE)) check("no_bubble", 128'(bus.o_valid), 128'(1));
        end
        drain();

        for (int j = 0; j < 800; j++) begin
            cycle($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0);
        end
        drain();

        // Backpressure: fill under stall, hold five cycles, then release.
        acc_cnt = 0;
        for (int j = 0; j < int'(PIPE) + 3; j++) cycle(1'b1, W'($urandom), 1'(j % 2), 1'b0);
        check("fill_count", 128'(acc_cnt), 128'(PIPE));
        for (int j = 0; j < 5; j++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        check("fill_hold", 128'(acc_cnt), 128'(PIPE));
        drain();

        // Asynchronous reset with a full pipeline.
        for (int j = 0; j < int'(PIPE); j++) cycle(1'b1, W'($urandom), 1'(j % 2), 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        #1 check("pre_reset_busy", 128'(bus.o_busy), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", 128'(bus.o_valid), 128'(0));
        check("async_busy",  128'(bus.o_busy),  128'(0));
        check("async_data",  128'(bus.o_data),  128'(0));
        check("async_ready", 128'(bus.o_ready), 128'(1));
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 32'hFF530100, 1'b0, 1'b1);
        drain();

        run_p1({32'h03020100, 32'h30201000, 32'h16ED7C63, 32'hFF530100}, 1'b0);
        run_p1({32'h03020100, 32'h30201000, 32'h16ED7C63, 32'hFF530100}, 1'b1);
        @(negedge clk);
        bus1.i_valid = 1'b1; bus1.i_data = {4{32'hFF530100}}; bus1.i_inverse = 1'b0;
        bus1.i_ready = 1'b0;
        @(negedge clk);
        bus1.i_data = {4{32'h12345678}};
        #1 check("p1_full_ready", 128'(bus1.o_ready), 128'(0));
        @(negedge clk);
        #1 check("p1_held_data", bus1.o_data, {4{32'h16ED7C63}});
        bus1.i_valid = 1'b0; bus1.i_ready = 1'b1;
        @(negedge clk);
        #1 check("p1_drained", 128'(bus1.o_valid), 128'(0));

        run_p3(8'h53, 1'b0);
        run_p3(8'hED, 1'b1);
        fill_p3();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
